// File: rtl/mix_load_sequencer_if.sv
// Issue / load-port / writeback bundle for mix_load_sequencer.
// Member names are given from the sequencer's point of view (_i into it, _o out of it).
// master: the sequencer itself; slave: the issue stage, memory and mix unit around it.
interface mix_load_sequencer_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TRANS_ID_W = 3
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [XLEN-1:0]       req_addr_i;
  logic [TRANS_ID_W-1:0] req_trans_id_i;

  logic                  ld_req_valid_o;
  logic                  ld_req_ready_i;
  logic [XLEN-1:0]       ld_addr_o;
  logic                  ld_rsp_valid_i;
  logic [XLEN-1:0]       ld_rsp_data_i;

  logic                  mix_valid_o;
  logic [XLEN-1:0]       mix_operand_a_o;
  logic [XLEN-1:0]       mix_operand_b_o;
  logic [TRANS_ID_W-1:0] mix_trans_id_o;

  logic                  ex_valid_o;
  logic [XLEN-1:0]       ex_cause_o;
  logic [XLEN-1:0]       ex_tval_o;
  logic [TRANS_ID_W-1:0] ex_trans_id_o;

  modport master (
    input  req_valid_i, req_addr_i, req_trans_id_i,
    input  ld_req_ready_i, ld_rsp_valid_i, ld_rsp_data_i,
    output req_ready_o,
    output ld_req_valid_o, ld_addr_o,
    output mix_valid_o, mix_operand_a_o, mix_operand_b_o, mix_trans_id_o,
    output ex_valid_o, ex_cause_o, ex_tval_o, ex_trans_id_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_trans_id_i,
    output ld_req_ready_i, ld_rsp_valid_i, ld_rsp_data_i,
    input  req_ready_o,
    input  ld_req_valid_o, ld_addr_o,
    input  mix_valid_o, mix_operand_a_o, mix_operand_b_o, mix_trans_id_o,
    input  ex_valid_o, ex_cause_o, ex_tval_o, ex_trans_id_o
  );
endinterface

// File: rtl/mix_load_sequencer.sv
// mix_load_sequencer: splits a halfword-misaligned word load (addr[1:0]==2'b10)
// into two aligned word loads (lo at addr&~3, hi at +4) and hands both words
// to the mix unit. Any other alignment raises a load-address-misaligned
// exception (cause 4). Handles flush, including draining one in-flight load.
// Optional: define MIX_SEQ_PERF_CNT_EN to add MIX/EXC pulse counters.
module mix_load_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TRANS_ID_W = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  mix_load_sequencer_if.master bus
`ifdef MIX_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_mix_cnt_o,
  output logic [31:0]          perf_exc_cnt_o
`endif
);

  localparam logic [XLEN-1:0] CAUSE_LD_MISALIGNED = XLEN'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_LO, S_WAIT_LO, S_REQ_HI, S_WAIT_HI, S_MIX, S_EXC, S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [TRANS_ID_W-1:0] id_q, id_d;
  logic [XLEN-1:0]       lo_q, lo_d;
  logic [XLEN-1:0]       hi_q, hi_d;
  logic [XLEN-1:0]       base_addr;

  assign base_addr = {addr_q[XLEN-1:2], 2'b00};

  // Registered operands and ids feed the writeback ports directly.
  assign bus.mix_operand_a_o = lo_q;
  assign bus.mix_operand_b_o = hi_q;
  assign bus.mix_trans_id_o  = id_q;
  assign bus.ex_tval_o       = addr_q;
  assign bus.ex_trans_id_o   = id_q;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Next-state and handshake outputs; flush gates every valid in its own cycle.
  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    id_d               = id_q;
    lo_d               = lo_q;
    hi_d               = hi_q;
    bus.req_ready_o    = 1'b0;
    bus.ld_req_valid_o = 1'b0;
    bus.ld_addr_o      = base_addr;
    bus.mix_valid_o    = 1'b0;
    bus.ex_valid_o     = 1'b0;
    bus.ex_cause_o     = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.req_ready_o = rst_ni & ~flush_i;
        if (!flush_i && bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          id_d    = bus.req_trans_id_i;
          state_d = (bus.req_addr_i[1:0] == 2'b10) ? S_REQ_LO : S_EXC;
        end
      end
      S_REQ_LO, S_REQ_HI: begin
        if (state_q == S_REQ_HI) begin
          bus.ld_addr_o = base_addr + XLEN'(4);
        end
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          bus.ld_req_valid_o = 1'b1;
          if (bus.ld_req_ready_i) begin
            // A response in the handshake cycle belongs to this request.
            if (bus.ld_rsp_valid_i) begin
              if (state_q == S_REQ_LO) begin
                lo_d    = bus.ld_rsp_data_i;
                state_d = S_REQ_HI;
              end else begin
                hi_d    = bus.ld_rsp_data_i;
                state_d = S_MIX;
              end
            end else begin
              state_d = (state_q == S_REQ_LO) ? S_WAIT_LO : S_WAIT_HI;
            end
          end
        end
      end
      S_WAIT_LO, S_WAIT_HI: begin
        if (bus.ld_rsp_valid_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else if (state_q == S_WAIT_LO) begin
            lo_d    = bus.ld_rsp_data_i;
            state_d = S_REQ_HI;
          end else begin
            hi_d    = bus.ld_rsp_data_i;
            state_d = S_MIX;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_MIX: begin
        bus.mix_valid_o = ~flush_i;
        state_d         = S_IDLE;
      end
      S_EXC: begin
        bus.ex_valid_o = ~flush_i;
        bus.ex_cause_o = flush_i ? '0 : CAUSE_LD_MISALIGNED;
        state_d        = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.ld_rsp_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MIX_SEQ_PERF_CNT_EN
  logic [31:0] perf_mix_q, perf_exc_q;

  assign perf_mix_cnt_o = perf_mix_q;
  assign perf_exc_cnt_o = perf_exc_q;

  // Pulse counters; flushed pulses are already suppressed on the valids.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_mix_q <= '0;
      perf_exc_q <= '0;
    end else begin
      if (bus.mix_valid_o) perf_mix_q <= perf_mix_q + 32'd1;
      if (bus.ex_valid_o)  perf_exc_q <= perf_exc_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mix_load_sequencer.sv
// Self-checking bench for mix_load_sequencer: transaction-level model plus
// directed scenarios and a randomized phase with random ready/response/flush.
module tb_mix_load_sequencer;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TIW  = 3;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic flush_i = 1'b0;

  mix_load_sequencer_if #(.XLEN(XLEN), .TRANS_ID_W(TIW)) bus ();

`ifdef MIX_SEQ_PERF_CNT_EN
  logic [31:0] perf_mix_cnt, perf_exc_cnt;
  mix_load_sequencer #(.XLEN(XLEN), .TRANS_ID_W(TIW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus),
    .perf_mix_cnt_o(perf_mix_cnt), .perf_exc_cnt_o(perf_exc_cnt)
  );
`else
  mix_load_sequencer #(.XLEN(XLEN), .TRANS_ID_W(TIW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus)
  );
`endif

  always #5 clk_i = ~clk_i;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned cyc        = 0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0000) return 32'hAABB_CCDD;
    if (a == 32'h1000_0004) return 32'h1122_3344;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory environment ----------------
  bit          rand_mode = 0, same_cycle = 0, hold_rsp = 0, stall = 0;
  bit          env_out   = 0;
  logic [31:0] env_out_addr = '0;
  logic [31:0] hs_log[$];

  always @(posedge clk_i) begin
    #2;
    if (!rst_ni) begin
      bus.ld_req_ready_i = 1'b0;
      bus.ld_rsp_valid_i = 1'b0;
      bus.ld_rsp_data_i  = '0;
    end else begin
      bus.ld_req_ready_i = stall ? 1'b0 : (rand_mode ? ($urandom_range(0, 9) < 6) : 1'b1);
      bus.ld_rsp_valid_i = 1'b0;
      bus.ld_rsp_data_i  = '0;
      if (env_out) begin
        if (!hold_rsp && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1)) begin
          bus.ld_rsp_valid_i = 1'b1;
          bus.ld_rsp_data_i  = mem_word(env_out_addr);
        end
      end else if (bus.ld_req_valid_o && bus.ld_req_ready_i &&
                   (rand_mode ? ($urandom_range(0, 9) < 3) : same_cycle)) begin
        bus.ld_rsp_valid_i = 1'b1;
        bus.ld_rsp_data_i  = mem_word(bus.ld_addr_o);
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      env_out = 0;
    end else if (bus.ld_req_valid_o && bus.ld_req_ready_i) begin
      hs_log.push_back(bus.ld_addr_o);
      if (!bus.ld_rsp_valid_i) begin
        env_out      = 1;
        env_out_addr = bus.ld_addr_o;
      end
    end else if (bus.ld_rsp_valid_i) begin
      env_out = 0;
    end
  end

  // ---------------- transaction-level model + compare ----------------
  bit          m_busy = 0, m_exc = 0, m_drain = 0;
  int unsigned m_nreq = 0, m_nrsp = 0;
  logic [31:0] m_addr = '0, m_lo = '0, m_hi = '0;
  logic [2:0]  m_id = '0;
  int unsigned m_mix_cnt = 0, m_exc_cnt = 0;
  bit          due, e_rdy, e_ldv;
  logic [31:0] e_base;

  int unsigned mix_seen = 0, ex_seen = 0, last_mix_cyc = 0, last_ex_cyc = 0;
  logic [31:0] last_mix_a = '0, last_mix_b = '0, last_ex_tval = '0, last_ex_cause = '0;
  logic [2:0]  last_mix_id = '0, last_ex_id = '0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_busy = 0; m_drain = 0; m_nreq = 0; m_nrsp = 0;
      m_mix_cnt = 0; m_exc_cnt = 0;
      check("rst_ld_valid", 32'(bus.ld_req_valid_o), 0);
      check("rst_mix_valid", 32'(bus.mix_valid_o), 0);
      check("rst_ex_valid", 32'(bus.ex_valid_o), 0);
    end else begin
      e_base = {m_addr[31:2], 2'b00};
      due    = m_busy && !m_drain && (m_exc || m_nrsp == 2);
      e_rdy  = !m_busy && !flush_i;
      e_ldv  = m_busy && !m_drain && !m_exc && m_nreq == m_nrsp && m_nreq < 2 && !flush_i;

      check("req_ready", 32'(bus.req_ready_o), 32'(e_rdy));
      check("ld_valid", 32'(bus.ld_req_valid_o), 32'(e_ldv));
      if (e_ldv) check("ld_addr", bus.ld_addr_o, e_base + 32'(4 * m_nreq));
      check("mix_valid", 32'(bus.mix_valid_o), 32'(due && !m_exc && !flush_i));
      if (due && !m_exc && !flush_i) begin
        check("mix_a", bus.mix_operand_a_o, m_lo);
        check("mix_b", bus.mix_operand_b_o, m_hi);
        check("mix_id", 32'(bus.mix_trans_id_o), 32'(m_id));
        m_mix_cnt++;
      end
      check("ex_valid", 32'(bus.ex_valid_o), 32'(due && m_exc && !flush_i));
      if (due && m_exc && !flush_i) begin
        check("ex_cause", bus.ex_cause_o, 32'd4);
        check("ex_tval", bus.ex_tval_o, m_addr);
        check("ex_id", 32'(bus.ex_trans_id_o), 32'(m_id));
        m_exc_cnt++;
      end

      if (bus.mix_valid_o) begin
        mix_seen++; last_mix_cyc = cyc;
        last_mix_a = bus.mix_operand_a_o; last_mix_b = bus.mix_operand_b_o;
        last_mix_id = bus.mix_trans_id_o;
      end
      if (bus.ex_valid_o) begin
        ex_seen++; last_ex_cyc = cyc;
        last_ex_tval = bus.ex_tval_o; last_ex_cause = bus.ex_cause_o;
        last_ex_id = bus.ex_trans_id_o;
      end

      // advance the model by this cycle's events
      if (m_busy) begin
        if (m_drain) begin
          if (bus.ld_rsp_valid_i) begin m_busy = 0; m_drain = 0; end
        end else if (flush_i) begin
          if (m_nreq > m_nrsp && !bus.ld_rsp_valid_i) m_drain = 1;
          else m_busy = 0;
        end else if (due) begin
          m_busy = 0;
        end else begin
          if (e_ldv && bus.ld_req_ready_i) m_nreq++;
          if (bus.ld_rsp_valid_i && m_nreq > m_nrsp) m_nrsp++;
        end
      end else if (!flush_i && bus.req_valid_i) begin
        m_busy = 1; m_drain = 0; m_nreq = 0; m_nrsp = 0;
        m_addr = bus.req_addr_i; m_id = bus.req_trans_id_i;
        m_exc  = (bus.req_addr_i[1:0] != 2'b10);
        m_lo   = mem_word({bus.req_addr_i[31:2], 2'b00});
        m_hi   = mem_word({bus.req_addr_i[31:2], 2'b00} + 32'd4);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned acc_cyc = 0;

  task automatic issue(input logic [31:0] a, input logic [2:0] id);
    int unsigned n;
    bit accepted;
    n = 0; accepted = 0;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.req_trans_id_i = id;
    while (!accepted && n < 100) begin
      @(negedge clk_i);
      if (bus.req_ready_o) begin accepted = 1; acc_cyc = cyc; end
      n++;
    end
    check("issue_accepted", 32'(accepted), 1);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (m_busy && n < 300) begin @(negedge clk_i); #1; n++; end
    check("idle_timeout", 32'(m_busy), 0);
  endtask

  task automatic wait_nreq(input int unsigned k);
    int unsigned n;
    n = 0;
    do begin @(negedge clk_i); #1; n++; end while (m_nreq != k && n < 100);
    check("nreq_timeout", m_nreq, k);
  endtask

  int unsigned base_mix;
  int unsigned base_hs;

  initial begin
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_trans_id_i = '0;
    bus.ld_req_ready_i = 1'b0; bus.ld_rsp_valid_i = 1'b0; bus.ld_rsp_data_i = '0;
    repeat (3) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(negedge clk_i); #1;
    check("reset_ready", 32'(bus.req_ready_o), 1);
    check("reset_ld_addr", bus.ld_addr_o, 0);

    // basic split load, responses one cycle after handshake
    base_mix = mix_seen;
    issue(32'h1000_0002, 3'd5);
    wait_idle();
    check("t1_mix_count", mix_seen - base_mix, 1);
    check("t1_mix_a", last_mix_a, 32'hAABB_CCDD);
    check("t1_mix_b", last_mix_b, 32'h1122_3344);
    check("t1_mix_id", 32'(last_mix_id), 5);
    check("t1_mix_result", (last_mix_a >> 16) | (last_mix_b << 16), 32'h3344_AABB);

    // misaligned -> exception one cycle after accept, no load
    base_hs = hs_log.size();
    issue(32'h2000_0001, 3'd2);
    wait_idle();
    check("t2_ex_cause", last_ex_cause, 4);
    check("t2_ex_tval", last_ex_tval, 32'h2000_0001);
    check("t2_ex_id", 32'(last_ex_id), 2);
    check("t2_ex_latency", last_ex_cyc - acc_cyc, 1);
    check("t2_no_load", hs_log.size() - base_hs, 0);

    // minimum latency with same-cycle responses
    same_cycle = 1;
    issue(32'h4000_0006, 3'd1);
    wait_idle();
    check("t3_mix_latency", last_mix_cyc - acc_cyc, 3);
    same_cycle = 0;

    // address wrap
    hs_log.delete();
    issue(32'hFFFF_FFFE, 3'd3);
    wait_idle();
    check("t4_hs_count", hs_log.size(), 2);
    if (hs_log.size() == 2) begin
      check("t4_lo_addr", hs_log[0], 32'hFFFF_FFFC);
      check("t4_hi_addr", hs_log[1], 32'h0000_0000);
    end

    // memory stalls 4 cycles in REQ_LO
    stall = 1;
    base_mix = mix_seen;
    issue(32'h3000_0002, 3'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      check("t5_stall_valid", 32'(bus.ld_req_valid_o), 1);
      check("t5_stall_addr", bus.ld_addr_o, 32'h3000_0000);
    end
    stall = 0;
    wait_idle();
    check("t5_mix_count", mix_seen - base_mix, 1);
    check("t5_mix_id", 32'(last_mix_id), 4);

    // flush in WAIT_HI -> drain one response, no mix
    base_mix = mix_seen;
    issue(32'h5000_000A, 3'd6);
    wait_nreq(2);
    hold_rsp = 1;
    @(posedge clk_i); #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i); #1;
    check("t6_drain_ready", 32'(bus.req_ready_o), 0);
    hold_rsp = 0;
    wait_idle();
    check("t6_no_mix", mix_seen - base_mix, 0);
    issue(32'h5000_0012, 3'd7);
    wait_idle();
    check("t6_next_mix", mix_seen - base_mix, 1);
    check("t6_next_a", last_mix_a, mem_word(32'h5000_0010));

    // async reset while in WAIT_LO
    hold_rsp = 1;
    issue(32'h6000_0002, 3'd7);
    wait_nreq(1);
    @(posedge clk_i); #3 rst_ni = 1'b0;
    #1;
    check("t7_rst_ld_valid", 32'(bus.ld_req_valid_o), 0);
    check("t7_rst_ld_addr", bus.ld_addr_o, 0);
    check("t7_rst_mix_a", bus.mix_operand_a_o, 0);
    check("t7_rst_ex_tval", bus.ex_tval_o, 0);
    env_out = 0; hold_rsp = 0;
    @(posedge clk_i); @(posedge clk_i); #3 rst_ni = 1'b1;
    @(negedge clk_i); #1;
    check("t7_ready_after_rst", 32'(bus.req_ready_o), 1);
    issue(32'h0000_0010, 3'd0);
    wait_idle();
    check("t7_ex_tval", last_ex_tval, 32'h0000_0010);
    issue(32'h0000_0012, 3'd1);
    wait_idle();
    check("t7_mix_a", last_mix_a, mem_word(32'h0000_0010));
    check("t7_mix_b", last_mix_b, mem_word(32'h0000_0014));

    // randomized phase
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a;
      @(posedge clk_i); #1;
      flush_i = ($urandom_range(0, 99) < 4);
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b10;
      if ($urandom_range(0, 19) == 0) a = 32'hFFFF_FFFE;
      bus.req_valid_i    = ($urandom_range(0, 1) == 1);
      bus.req_addr_i     = a;
      bus.req_trans_id_i = 3'($urandom);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0; bus.req_valid_i = 1'b0;
    wait_idle();
    rand_mode = 0;

`ifdef MIX_SEQ_PERF_CNT_EN
    @(negedge clk_i); #1;
    check("perf_mix", perf_mix_cnt, m_mix_cnt);
    check("perf_exc", perf_exc_cnt, m_exc_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
